char_buffer_arbiter: RTL

Shares the single-port synchronous char buffer RAM between the video generator's read stream and a write client (terminal command engine). It also runs a hardware row-fill engine that writes FILL_CHAR into COLS consecutive cells, used when scrolling or erasing lines. It runs at the memory clock, which is twice the pixel clock. Even cycles are video slots; odd cycles are client slots.

---
 rtl/char_buffer_pkg.sv | 20 ++
 rtl/char_buffer_fill_engine.sv | 93 +++++++++
 rtl/char_buffer_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/char_buffer_pkg.sv
// Shared constants and types for the character buffer and its clients
// (video generator, terminal command engine, arbiter).
package char_buffer_pkg;

  localparam int         ROWS_DEFAULT      = 24;
  localparam int         COLS_DEFAULT      = 80;
  localparam int         ADDR_BITS_DEFAULT = 11;
  localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // First address beyond the visible text area; valid cells are below it.
  function automatic int past_last(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/char_buffer_fill_engine.sv
// Row-fill engine: walks COLS consecutive cells (wrapping at the end of the
// ring buffer), emitting one write per client slot while busy.
module char_buffer_fill_engine
  import char_buffer_pkg::*;
#(
  parameter int ROWS      = ROWS_DEFAULT,
  parameter int COLS      = COLS_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int CNT_BITS  = $clog2(COLS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 slot_i,
  input  logic                 fill_req_i,
  input  logic [ADDR_BITS-1:0] fill_start_i,
  output logic                 fill_busy_o,
  output logic                 fill_done_o,
  output logic [ADDR_BITS-1:0] fill_ptr_o
);

  localparam int                   PAST_LAST   = past_last(ROWS, COLS);
  localparam logic [ADDR_BITS-1:0] PAST_LAST_A = ADDR_BITS'(PAST_LAST);
  localparam logic [ADDR_BITS-1:0] LAST_A      = ADDR_BITS'(PAST_LAST - 1);
  localparam logic [CNT_BITS-1:0]  CNT_INIT    = CNT_BITS'(COLS);
  localparam logic [CNT_BITS-1:0]  CNT_ONE     = CNT_BITS'(1);

  fill_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= {ADDR_BITS{1'b0}};
      cnt_q   <= {CNT_BITS{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Requests are only accepted when idle; out-of-range starts are dropped.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_req_i && (fill_start_i < PAST_LAST_A)) begin
          state_d = FILL;
          ptr_d   = fill_start_i;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      FILL: begin
        if (slot_i) begin
          ptr_d = (ptr_q == LAST_A) ? {ADDR_BITS{1'b0}} : ptr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign fill_busy_o = busy_q;
  assign fill_done_o = done_q;
  assign fill_ptr_o  = ptr_q;

endmodule

// File: rtl/char_buffer_arbiter.sv
// Time-slot arbiter for the single-port char buffer RAM: even cycles serve the
// video reader, odd cycles the fill engine or the write client.
// Optional client reads: define CHAR_BUFFER_CLIENT_READ_EN.
module char_buffer_arbiter
  import char_buffer_pkg::*;
#(
  parameter int         ROWS      = ROWS_DEFAULT,
  parameter int         COLS      = COLS_DEFAULT,
  parameter int         ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] vid_addr,
  output logic [7:0]           vid_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
`ifdef CHAR_BUFFER_CLIENT_READ_EN
  input  logic                 wr_read,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
`endif
  input  logic                 fill_req,
  input  logic [ADDR_BITS-1:0] fill_start,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  localparam logic [ADDR_BITS-1:0] PAST_LAST_A = ADDR_BITS'(past_last(ROWS, COLS));

  logic                 phase_q;
  logic [7:0]           vid_data_q;
  logic [ADDR_BITS-1:0] fill_ptr_s;
  logic                 wr_in_range_s;

  char_buffer_fill_engine #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fill (
    .clk          (clk),
    .reset_n      (reset_n),
    .slot_i       (phase_q),
    .fill_req_i   (fill_req),
    .fill_start_i (fill_start),
    .fill_busy_o  (fill_busy),
    .fill_done_o  (fill_done),
    .fill_ptr_o   (fill_ptr_s)
  );

  assign wr_in_range_s = (wr_addr < PAST_LAST_A);

  // The RAM result of a phase-0 read is on ram_rdata during phase 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= 1'b0;
      vid_data_q <= 8'h00;
    end else begin
      phase_q <= ~phase_q;
      if (phase_q) begin
        vid_data_q <= ram_rdata;
      end else begin
        vid_data_q <= vid_data_q;
      end
    end
  end

  assign vid_data = vid_data_q;

`ifdef CHAR_BUFFER_CLIENT_READ_EN
  logic       client_rd_s;
  logic       rd_pend_q;
  logic       rd_oor_q;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;

  // A client read issued in phase 1 lands on ram_rdata in the following phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else if (phase_q) begin
      rd_pend_q  <= client_rd_s;
      rd_oor_q   <= ~wr_in_range_s;
      rd_valid_q <= 1'b0;
    end else begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= rd_oor_q ? 8'h00 : ram_rdata;
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  // Slot mux: video in phase 0; fill engine beats the client in phase 1.
  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    wr_ready  = 1'b0;
`ifdef CHAR_BUFFER_CLIENT_READ_EN
    client_rd_s = 1'b0;
`endif
    if (phase_q) begin
      if (fill_busy) begin
        ram_addr  = fill_ptr_s;
        ram_we    = 1'b1;
        ram_wdata = FILL_CHAR;
      end else begin
        wr_ready  = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
`ifdef CHAR_BUFFER_CLIENT_READ_EN
        client_rd_s = wr_valid & wr_read;
        ram_we      = wr_valid & ~wr_read & wr_in_range_s;
`else
        ram_we      = wr_valid & wr_in_range_s;
`endif
      end
    end else begin
      ram_addr = vid_addr;
    end
  end

endmodule
